// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin shared W-bit adder/subtractor with a registered result buffer and Y86 flags
module addsub_arbiter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_sub,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_sub,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_result,
   output logic         rsp_zf,
   output logic         rsp_sf,
   output logic         rsp_of
);
   logic         last_grant, can_accept, gnt0, gnt1, sub, c_msb, c_out;
   logic [W-1:0] a, b, bx, sum;
   logic [W-2:0] low;
   // grant, handshake and the single shared adder; the MSB is added separately to expose carry into it
   always_comb begin
      can_accept = !rsp_valid | rsp_ready;
      gnt0 = req0_valid & (!req1_valid | last_grant);
      gnt1 = req1_valid & (!req0_valid | !last_grant);
      req0_ready = rst_n & can_accept & gnt0;
      req1_ready = rst_n & can_accept & gnt1;
      a = gnt1 ? req1_a : req0_a;
      b = gnt1 ? req1_b : req0_b;
      sub = gnt1 ? req1_sub : req0_sub;
      bx = sub ? ~b : b;
      {c_msb, low} = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, sub};
      {c_out, sum[W-1]} = {1'b0, a[W-1]} + {1'b0, bx[W-1]} + {1'b0, c_msb};
      sum[W-2:0] = low;
   end
   // output buffer: load on transfer, drain when consumed, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zf     <= 1'b0;
         rsp_sf     <= 1'b0;
         rsp_of     <= 1'b0;
         last_grant <= 1'b1;
      end else if (req0_ready | req1_ready) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= gnt1;
         rsp_result <= sum;
         rsp_zf     <= ~|sum;
         rsp_sf     <= sum[W-1];
         rsp_of     <= c_msb ^ c_out;
         last_grant <= gnt1;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: randomized and directed checks against a behavioural arbiter/ALU model
module tb_addsub_arbiter;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic        v0 = 0, v1 = 0, s0 = 0, s1 = 0, rr = 0;
   logic [63:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic        rdy0, rdy1, rsp_valid, rsp_id, rsp_zf, rsp_sf, rsp_of;
   logic [63:0] rsp_result;
   int          checks = 0, errors = 0;
   logic        m_valid, m_id, m_zf, m_sf, m_of;
   logic [63:0] m_res;
   int          m_last;

   addsub_arbiter #(.W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0), .req0_a(a0), .req0_b(b0), .req0_sub(s0),
      .req1_valid(v1), .req1_ready(rdy1), .req1_a(a1), .req1_b(b1), .req1_sub(s1),
      .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_res = 0; m_zf = 0; m_sf = 0; m_of = 0; m_last = 1;
   endtask

   function automatic int pick();
      if (m_valid && !rr) return -1;
      if (v0 && v1) return (m_last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic model_load(input int id, input logic [63:0] a, input logic [63:0] b, input logic s);
      m_res = s ? a - b : a + b;
      m_valid = 1; m_id = id[0]; m_last = id;
      m_zf = (m_res == 0);
      m_sf = m_res[63];
      m_of = s ? (a[63] != b[63] && m_res[63] != a[63]) : (a[63] == b[63] && m_res[63] != a[63]);
   endtask

   task automatic tick();
      int p;
      p = pick();
      @(posedge clk);
      if (p == 0) model_load(0, a0, b0, s0);
      else if (p == 1) model_load(1, a1, b1, s1);
      else if (m_valid && rr) m_valid = 0;
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 0;
      model_reset();
      v0 = 1; v1 = 1; rr = $urandom_range(0, 1);
      a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      #2;
      checks++;
      if ({rsp_valid, rsp_id, rsp_zf, rsp_sf, rsp_of, rdy0, rdy1} !== 7'b0 || rsp_result !== 64'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b id=%b r=%h zf=%b sf=%b of=%b rdy=%b%b, want all 0",
                  rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of, rdy0, rdy1);
      end
      @(negedge clk);
      v0 = 0; v1 = 0; rr = 1; rst_n = 1;
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_single_add();
      @(negedge clk);
      v0 = 1; a0 = 5; b0 = 7; s0 = 0; rr = 1;
      #1;
      checks++;
      if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin errors++; $display("FAIL add_ready: rdy0=%b rdy1=%b want 1 0", rdy0, rdy1); end
      tick();
      v0 = 0;
      checks++;
      if (rsp_valid !== 1 || rsp_id !== 0 || rsp_result !== 64'd12 || {rsp_zf, rsp_sf, rsp_of} !== 3'b000) begin
         errors++;
         $display("FAIL add_result: v=%b id=%b r=%0d f=%b%b%b want 1 0 12 000", rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of);
      end
      tick();
   endtask

   task automatic test_flags();
      logic [63:0] ta [4] = '{64'd3, 64'd0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
      logic [63:0] tb [4] = '{64'd3, 64'd1, 64'd1, 64'd1};
      logic        ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [63:0] tr [4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
      logic [2:0]  tf [4] = '{3'b100, 3'b010, 3'b001, 3'b011};
      rr = 1;
      for (int i = 0; i < 4; i++) begin
         v1 = 1; a1 = ta[i]; b1 = tb[i]; s1 = ts[i];
         tick();
         checks++;
         if (rsp_valid !== 1 || rsp_id !== 1 || rsp_result !== tr[i] || {rsp_zf, rsp_sf, rsp_of} !== tf[i]) begin
            errors++;
            $display("FAIL flags_%0d: v=%b id=%b r=%h zso=%b%b%b want 1 1 %h %b", i, rsp_valid, rsp_id, rsp_result,
                     rsp_zf, rsp_sf, rsp_of, tr[i], tf[i]);
         end
      end
      v1 = 0;
      tick();
   endtask

   task automatic test_contention();
      rr = 1; v0 = 1; v1 = 1;
      for (int i = 0; i < 6; i++) begin
         a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; s0 = $urandom_range(0, 1);
         a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; s1 = $urandom_range(0, 1);
         #1;
         checks++;
         if (rdy0 !== (i % 2 == 0) || rdy1 !== (i % 2 == 1)) begin
            errors++; $display("FAIL contention_ready_%0d: rdy0=%b rdy1=%b want %b %b", i, rdy0, rdy1, i % 2 == 0, i % 2 == 1);
         end
         tick();
         checks++;
         if (rsp_valid !== 1 || rsp_id !== i[0] || rsp_result !== m_res || {rsp_zf, rsp_sf, rsp_of} !== {m_zf, m_sf, m_of}) begin
            errors++;
            $display("FAIL contention_rsp_%0d: v=%b id=%b r=%h f=%b%b%b want 1 %b %h %b%b%b", i, rsp_valid, rsp_id,
                     rsp_result, rsp_zf, rsp_sf, rsp_of, i[0], m_res, m_zf, m_sf, m_of);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] held;
      rr = 1; v0 = 1; v1 = 1;
      a0 = 64'd100; b0 = 64'd1; s0 = 1; a1 = 64'd40; b1 = 64'd2; s1 = 0;
      tick();
      held = rsp_result;
      checks++;
      if (rsp_valid !== 1 || rsp_id !== 0 || held !== 64'd99) begin
         errors++; $display("FAIL bp_fill: v=%b id=%b r=%0d want 1 0 99", rsp_valid, rsp_id, held);
      end
      rr = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (rdy0 !== 0 || rdy1 !== 0) begin errors++; $display("FAIL bp_ready_%0d: rdy=%b%b want 00", i, rdy0, rdy1); end
         tick();
         checks++;
         if (rsp_valid !== 1 || rsp_id !== 0 || rsp_result !== 64'd99) begin
            errors++; $display("FAIL bp_hold_%0d: v=%b id=%b r=%0d want 1 0 99", i, rsp_valid, rsp_id, rsp_result);
         end
      end
      rr = 1;
      #1;
      checks++;
      if (rdy0 !== 0 || rdy1 !== 1) begin errors++; $display("FAIL bp_release_ready: rdy=%b%b want 01", rdy0, rdy1); end
      tick();
      checks++;
      if (rsp_valid !== 1 || rsp_id !== 1 || rsp_result !== 64'd42) begin
         errors++; $display("FAIL bp_release: v=%b id=%b r=%0d want 1 1 42", rsp_valid, rsp_id, rsp_result);
      end
      v0 = 0; v1 = 0;
      tick();
   endtask

   task automatic test_random();
      int p;
      v0 = 0; v1 = 0;
      for (int i = 0; i < 400; i++) begin
         rr = ($urandom_range(0, 3) != 0);
         #1;
         p = pick();
         checks++;
         if (rdy0 !== (p == 0) || rdy1 !== (p == 1)) begin
            errors++; $display("FAIL rand_ready_%0d: rdy=%b%b want %b%b", i, rdy0, rdy1, p == 0, p == 1);
         end
         tick();
         checks++;
         if (rsp_valid !== m_valid || (m_valid && (rsp_id !== m_id || rsp_result !== m_res ||
             {rsp_zf, rsp_sf, rsp_of} !== {m_zf, m_sf, m_of}))) begin
            errors++;
            $display("FAIL rand_rsp_%0d: v=%b id=%b r=%h f=%b%b%b want %b %b %h %b%b%b", i, rsp_valid, rsp_id, rsp_result,
                     rsp_zf, rsp_sf, rsp_of, m_valid, m_id, m_res, m_zf, m_sf, m_of);
         end
         if (!v0 || p == 0) begin
            v0 = $urandom_range(0, 1); s0 = $urandom_range(0, 1);
            a0 = ($urandom_range(0, 7) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            b0 = ($urandom_range(0, 7) == 0) ? a0 : {$urandom, $urandom};
         end
         if (!v1 || p == 1) begin
            v1 = $urandom_range(0, 1); s1 = $urandom_range(0, 1);
            a1 = ($urandom_range(0, 7) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            b1 = ($urandom_range(0, 7) == 0) ? a1 : {$urandom, $urandom};
         end
      end
      v0 = 0; v1 = 0; rr = 1;
      tick();
   endtask

   task automatic test_reset_mid();
      rr = 1; v0 = 1; v1 = 1;
      a0 = 64'd9; b0 = 64'd4; s0 = 0; a1 = 64'd8; b1 = 64'd8; s1 = 1;
      for (int i = 0; i < 3; i++) tick();
      @(negedge clk);
      rst_n = 0;
      model_reset();
      #1;
      checks++;
      if (rsp_valid !== 0 || rdy0 !== 0 || rdy1 !== 0) begin
         errors++; $display("FAIL midreset_drop: v=%b rdy=%b%b want 0 00", rsp_valid, rdy0, rdy1);
      end
      #1 rst_n = 1;
      #1;
      checks++;
      if (rdy0 !== 1 || rdy1 !== 0) begin errors++; $display("FAIL midreset_grant_ready: rdy=%b%b want 10", rdy0, rdy1); end
      tick();
      checks++;
      if (rsp_valid !== 1 || rsp_id !== 0 || rsp_result !== 64'd13) begin
         errors++; $display("FAIL midreset_first: v=%b id=%b r=%0d want 1 0 13", rsp_valid, rsp_id, rsp_result);
      end
      v0 = 0; v1 = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_flags();
      test_contention();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
